line_cmd_seq: RTL and testbench

Parametrised command sequencer for the line-following robot. It buffers up to DEPTH fork-direction commands received from the UART wrapper and steps through each command's 2-bit directives as the line is lost and reacquired. It drives go, the signed open-loop steering error and the buzzer, with bumper-stop handling. It sits between UART_wrapper and the motion/PID path. Relative to the previous generation it adds a command FIFO, a command-completion pulse and fully parametrised widths, timers and magnitudes.

---
 rtl/line_cmd_seq.sv | 167 ++++++++++++++++
 tb/tb_line_cmd_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_seq.sv
// Command sequencer for the line-following robot: queues fork-direction commands
// and steps through their 2-bit directives as the line is lost and reacquired.
module line_cmd_seq #(
   parameter int unsigned       CMD_W    = 16,
   parameter int unsigned       DEPTH    = 2,
   parameter int unsigned       ERR_W    = 16,
   parameter logic [ERR_W-1:0]  VEER_MAG = 16'h340,
   parameter logic [ERR_W-1:0]  REV1_MAG = 16'h1E0,
   parameter logic [ERR_W-1:0]  REV2_MAG = 16'h380,
   parameter int unsigned       REV1_CYC = 22 << 16,
   parameter int unsigned       REV2_CYC = 31 << 21,
   parameter int unsigned       DBNC_CYC = 1 << 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CMD_W-1:0] cmd,
   input  logic             cmd_rdy,
   output logic             clr_cmd_rdy,
   input  logic             line_present,
   input  logic             BMPL_n,
   input  logic             BMPR_n,
   output logic             go,
   output logic [ERR_W-1:0] err_opn_lp,
   output logic             buzz,
   output logic             cmd_done,
   output logic             fifo_full
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned MAX12   = (REV1_CYC > REV2_CYC) ? REV1_CYC : REV2_CYC;
   localparam int unsigned MAX_CYC = (MAX12 > DBNC_CYC) ? MAX12 : DBNC_CYC;
   localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TMR_W-1:0] REV1_LAST = TMR_W'(REV1_CYC - 1);
   localparam logic [TMR_W-1:0] REV2_LAST = TMR_W'(REV2_CYC - 1);
   localparam logic [TMR_W-1:0] DBNC_LAST = TMR_W'(DBNC_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, FOLLOW, VEER, REV1, REV2, REACQ, BUMP_DBNC, BUMP_HOLD
   } state_t;

   state_t             state, state_n;
   logic [CMD_W-1:0]   shreg, shreg_n;
   logic               lvr, lvr_n;
   logic [TMR_W-1:0]   tmr, tmr_n;
   logic               done_n, go_n, buzz_n;
   logic [ERR_W-1:0]   err_n;

   logic [CMD_W-1:0]   mem [DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               empty, full, req, pop, push, bump;
   logic [CMD_W-1:0]   head;
   logic [1:0]         dir;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fifo_full = full;
   // cmd_rdy is still high in the cycle clr_cmd_rdy is out; don't capture it twice
   assign req  = cmd_rdy && !clr_cmd_rdy;
   // An empty FIFO forwards the incoming command straight to the shift register
   assign head = empty ? cmd : mem[rd_ptr[AW-1:0]];
   assign pop  = (state == IDLE) && line_present && (!empty || req);
   assign push = req && (!full || pop);
   assign bump = !BMPL_n || !BMPR_n;
   assign dir  = shreg[1:0];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= cmd;
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      lvr_n   = lvr;
      tmr_n   = tmr;
      done_n  = 1'b0;
      case (state)
         IDLE: if (pop) begin
            state_n = FOLLOW;
            shreg_n = head;
         end
         FOLLOW: if (bump) begin
            state_n = BUMP_DBNC;
            tmr_n   = '0;
         end else if (!line_present) begin
            case (dir)
               2'b00: begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
               2'b01, 2'b10: state_n = VEER;
               default: begin
                  state_n = REV1;
                  tmr_n   = '0;
               end
            endcase
         end
         VEER: if (line_present) begin
            shreg_n = shreg >> 2;
            lvr_n   = dir[0];
            state_n = FOLLOW;
         end
         REV1: if (tmr == REV1_LAST) begin
            tmr_n   = '0;
            state_n = REV2;
         end else begin
            tmr_n = tmr + 1'b1;
         end
         REV2: if (tmr == REV2_LAST) begin
            tmr_n   = '0;
            state_n = REACQ;
         end else begin
            tmr_n = tmr + 1'b1;
         end
         REACQ: if (line_present) begin
            shreg_n = shreg >> 2;
            state_n = FOLLOW;
         end
         BUMP_DBNC: if (tmr == DBNC_LAST) begin
            tmr_n   = '0;
            state_n = bump ? BUMP_HOLD : FOLLOW;
         end else begin
            tmr_n = tmr + 1'b1;
         end
         BUMP_HOLD: if (!bump) state_n = FOLLOW;
         default: state_n = IDLE;
      endcase

      // Outputs are decoded from next-state values so the registered copies track state
      go_n   = !(state_n == IDLE || state_n == BUMP_DBNC || state_n == BUMP_HOLD);
      buzz_n = (state_n == BUMP_DBNC) || (state_n == BUMP_HOLD);
      case (state_n)
         VEER:    err_n = shreg_n[0] ? VEER_MAG : ('0 - VEER_MAG);
         REV1:    err_n = lvr_n ? REV1_MAG : ('0 - REV1_MAG);
         REV2:    err_n = lvr_n ? ('0 - REV2_MAG) : REV2_MAG;
         default: err_n = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         lvr         <= 1'b0;
         tmr         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         clr_cmd_rdy <= 1'b0;
         cmd_done    <= 1'b0;
         go          <= 1'b0;
         buzz        <= 1'b0;
         err_opn_lp  <= '0;
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         lvr         <= lvr_n;
         tmr         <= tmr_n;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         clr_cmd_rdy <= push;
         cmd_done    <= done_n;
         go          <= go_n;
         buzz        <= buzz_n;
         err_opn_lp  <= err_n;
      end
   end

endmodule

// File: tb/tb_line_cmd_seq.sv
// Directed bench for line_cmd_seq: a vector table for the basic command flow plus
// hand-written sequences for gap timing, FIFO full, bumper debounce and async reset.
module tb_line_cmd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cmd = '0;
   logic        cmd_rdy = 1'b0;
   logic        clr_cmd_rdy;
   logic        line_present = 1'b0;
   logic        BMPL_n = 1'b1;
   logic        BMPR_n = 1'b1;
   logic        go;
   logic [15:0] err_opn_lp;
   logic        buzz;
   logic        cmd_done;
   logic        fifo_full;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   line_cmd_seq #(
      .CMD_W(16), .DEPTH(2), .ERR_W(16),
      .VEER_MAG(16'h340), .REV1_MAG(16'h1E0), .REV2_MAG(16'h380),
      .REV1_CYC(10), .REV2_CYC(16), .DBNC_CYC(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .line_present(line_present),
      .BMPL_n(BMPL_n), .BMPR_n(BMPR_n), .go(go), .err_opn_lp(err_opn_lp),
      .buzz(buzz), .cmd_done(cmd_done), .fifo_full(fifo_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic [15:0] c;
      logic        line;
      logic        go;
      logic [15:0] err;
      logic        buzz;
      logic        clr;
      logic        done;
      logic        full;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic g, input logic [15:0] e,
                          input logic b, input logic cl, input logic d, input logic f);
      chk({tag, ".go"},   {15'd0, go},          {15'd0, g});
      chk({tag, ".err"},  err_opn_lp,           e);
      chk({tag, ".buzz"}, {15'd0, buzz},        {15'd0, b});
      chk({tag, ".clr"},  {15'd0, clr_cmd_rdy}, {15'd0, cl});
      chk({tag, ".done"}, {15'd0, cmd_done},    {15'd0, d});
      chk({tag, ".full"}, {15'd0, fifo_full},   {15'd0, f});
   endtask

   initial begin
      //         rdy  cmd       line  go    err       buzz  clr   done  full
      tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0340, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0340, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFCC0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

      #23;
      chk_all("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk_all("post_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 14; i++) begin
         cmd_rdy      = tbl[i].rdy;
         cmd          = tbl[i].c;
         line_present = tbl[i].line;
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].go, tbl[i].err, tbl[i].buzz,
                 tbl[i].clr, tbl[i].done, tbl[i].full);
      end

      // Gap directive with last_veer_right=0: -REV1 for 10, +REV2 for 16, then 0
      line_present = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("rev1_%0d", i), err_opn_lp, 16'hFE20);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("rev2_%0d", i), err_opn_lp, 16'h0380);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all($sformatf("reacq_%0d", i), 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      line_present = 1'b1;
      tick();
      chk_all("reacq_found", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      line_present = 1'b0;
      tick();
      chk_all("gap_done", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

      // Fill the FIFO while idle and off the line
      cmd_rdy = 1'b1; cmd = 16'h0001;
      tick();
      chk_all("push_a", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      cmd_rdy = 1'b0;
      tick();
      chk("push_a_clr_end", {15'd0, clr_cmd_rdy}, 16'd0);
      cmd_rdy = 1'b1; cmd = 16'h0002;
      tick();
      chk_all("push_b", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
      cmd_rdy = 1'b0;
      tick();
      cmd_rdy = 1'b1; cmd = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all($sformatf("push_c_blocked%0d", i), 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      line_present = 1'b1;
      tick();
      chk_all("push_pop_full", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
      cmd_rdy = 1'b0;
      tick();
      chk_all("after_push_pop", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Held bumper: 8 debounce cycles, then hold while pressed
      BMPL_n = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick();
         chk($sformatf("bump_go%0d", i),   {15'd0, go},   16'd0);
         chk($sformatf("bump_buzz%0d", i), {15'd0, buzz}, 16'd1);
      end
      BMPL_n = 1'b1;
      tick();
      chk_all("bump_release", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Short bumper pulse: back to FOLLOW as soon as debounce expires
      BMPR_n = 1'b0;
      tick();
      BMPR_n = 1'b1;
      chk("short_first_buzz", {15'd0, buzz}, 16'd1);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("short_go%0d", i),   {15'd0, go},   16'd0);
         chk($sformatf("short_buzz%0d", i), {15'd0, buzz}, 16'd1);
      end
      tick();
      chk_all("short_end", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Fresh start: queue a gap command and another behind it, reset during REV2
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      cmd_rdy = 1'b1; cmd = 16'h0003; line_present = 1'b1;
      tick();
      chk_all("gap2_start", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      cmd_rdy = 1'b0;
      tick();
      cmd_rdy = 1'b1; cmd = 16'h0001;
      tick();
      chk("queued_clr", {15'd0, clr_cmd_rdy}, 16'd1);
      cmd_rdy = 1'b0; line_present = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      chk("rev2_before_reset", err_opn_lp, 16'h0380);
      #3 rst_n = 1'b0;
      #1;
      chk_all("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;
      line_present = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all($sformatf("fifo_cleared%0d", i), 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      cmd_rdy = 1'b1; cmd = 16'h0001;
      tick();
      chk_all("restart", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      cmd_rdy = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
